// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and queue entry type for the instruction fetch queue
package fetch_pkg;

   // Instruction word presented when nothing valid is available (addi x0,x0,0)
   localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
   localparam int          DEFAULT_QDEPTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        misalign;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch queue storage, pointers and occupancy count (misalign bit stored only with FETCH_MISALIGN_CHK_EN)
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int QDEPTH = DEFAULT_QDEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  fetch_entry_t             wr_entry,
   input  logic                     rd_en,
   input  logic                     flush,
   output fetch_entry_t             rd_entry,
   output logic [$clog2(QDEPTH):0]  count
);

   localparam int PTR_W = $clog2(QDEPTH);

   logic [31:0]      pc_mem    [QDEPTH];
   logic [31:0]      instr_mem [QDEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointer and count bookkeeping; flush wins over any write or pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry payload storage; contents are meaningless until count covers them
   always_ff @(posedge clk) begin
      if (wr_en) begin
         pc_mem[wr_ptr]    <= wr_entry.pc;
         instr_mem[wr_ptr] <= wr_entry.instr;
      end
   end

`ifdef FETCH_MISALIGN_CHK_EN
   logic misalign_mem [QDEPTH];

   // Per-entry misalignment flag
   always_ff @(posedge clk) begin
      if (wr_en) misalign_mem[wr_ptr] <= wr_entry.misalign;
   end

   // Head entry read-out
   always_comb begin
      rd_entry.pc       = pc_mem[rd_ptr];
      rd_entry.instr    = instr_mem[rd_ptr];
      rd_entry.misalign = misalign_mem[rd_ptr];
   end
`else
   logic unused_misalign;
   assign unused_misalign = wr_entry.misalign;

   // Head entry read-out; no misalign state exists in this build
   always_comb begin
      rd_entry.pc       = pc_mem[rd_ptr];
      rd_entry.instr    = instr_mem[rd_ptr];
      rd_entry.misalign = 1'b0;
   end
`endif

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - IF stage fetch queue: accept, in-flight tracking and flush control (option FETCH_MISALIGN_CHK_EN)
module if_fetch_queue #(
   parameter int          QDEPTH    = fetch_pkg::DEFAULT_QDEPTH,
   parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic        ip_clk,
   input  logic        ip_rst,
   input  logic [31:0] ip_pc,
   input  logic        ip_pc_valid,
   output logic        op_pc_ready,
   output logic        op_imem_req,
   output logic [31:0] op_imem_addr,
   input  logic [31:0] ip_imem_rdata,
   input  logic        ip_stall,
   input  logic        ip_flush,
   output logic        op_if_valid,
   output logic [31:0] op_if_pc,
   output logic [31:0] op_if_instr,
   output logic        op_misalign
);
   import fetch_pkg::*;

   localparam int               PTR_W   = $clog2(QDEPTH);
   localparam logic [PTR_W+1:0] DEPTH_V = (PTR_W+2)'(QDEPTH);

   logic [PTR_W:0]   count;
   logic [PTR_W+1:0] occupancy;
   logic             inflight;
   logic [31:0]      pc_q;
   logic [31:0]      pc_store;
   logic             accept;
   logic             wr_en;
   logic             pop;
   fetch_entry_t     wr_entry;
   fetch_entry_t     head;

   // A slot is reserved for the in-flight response so a write can never hit a full queue
   assign occupancy    = {1'b0, count} + {{(PTR_W+1){1'b0}}, inflight};
   assign op_pc_ready  = !ip_rst && !ip_flush && (occupancy < DEPTH_V);
   assign accept       = ip_pc_valid && op_pc_ready;
   assign op_imem_req  = accept;
   assign op_imem_addr = {ip_pc[31:2], 2'b00};

   // A flush in the response cycle drops the returning word
   assign wr_en        = inflight && !ip_flush;
   assign pop          = op_if_valid && !ip_stall;
   assign op_if_valid  = (count != '0);

`ifdef FETCH_MISALIGN_CHK_EN
   assign pc_store          = ip_pc;
   assign wr_entry.misalign = |pc_q[1:0];
`else
   logic unused_pc_lsb;
   assign unused_pc_lsb     = ^ip_pc[1:0];
   assign pc_store          = {ip_pc[31:2], 2'b00};
   assign wr_entry.misalign = 1'b0;
`endif
   assign wr_entry.pc    = pc_q;
   assign wr_entry.instr = ip_imem_rdata;

   // Track the single outstanding memory read and remember its PC for the response cycle
   always_ff @(posedge ip_clk or posedge ip_rst) begin
      if (ip_rst) begin
         inflight <= 1'b0;
         pc_q     <= '0;
      end else begin
         inflight <= accept;
         if (accept) pc_q <= pc_store;
      end
   end

   fetch_fifo #(.QDEPTH(QDEPTH)) u_fifo (
      .clk      (ip_clk),
      .rst      (ip_rst),
      .wr_en    (wr_en),
      .wr_entry (wr_entry),
      .rd_en    (pop),
      .flush    (ip_flush),
      .rd_entry (head),
      .count    (count)
   );

`ifdef FETCH_MISALIGN_CHK_EN
   // Head presentation; a misaligned head shows a NOP and raises the flag
   always_comb begin
      op_if_pc    = '0;
      op_if_instr = NOP_INSTR;
      op_misalign = 1'b0;
      if (op_if_valid) begin
         op_if_pc    = head.pc;
         op_misalign = head.misalign;
         op_if_instr = head.misalign ? NOP_INSTR : head.instr;
      end
   end
`else
   logic unused_head_misalign;
   assign unused_head_misalign = head.misalign;

   // Head presentation; empty queue shows PC 0 and a NOP
   always_comb begin
      op_if_pc    = '0;
      op_if_instr = NOP_INSTR;
      op_misalign = 1'b0;
      if (op_if_valid) begin
         op_if_pc    = head.pc;
         op_if_instr = head.instr;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed self-checking bench for if_fetch_queue
`timescale 1ns/1ps
module tb_if_fetch_queue;

   logic        ip_clk = 1'b0;
   logic        ip_rst;
   logic [31:0] ip_pc;
   logic        ip_pc_valid;
   logic        op_pc_ready;
   logic        op_imem_req;
   logic [31:0] op_imem_addr;
   logic [31:0] ip_imem_rdata;
   logic        ip_stall;
   logic        ip_flush;
   logic        op_if_valid;
   logic [31:0] op_if_pc;
   logic [31:0] op_if_instr;
   logic        op_misalign;

   int errors = 0;
   int checks = 0;

   logic        req_d;
   logic [31:0] addr_d;

   if_fetch_queue dut (
      .ip_clk        (ip_clk),
      .ip_rst        (ip_rst),
      .ip_pc         (ip_pc),
      .ip_pc_valid   (ip_pc_valid),
      .op_pc_ready   (op_pc_ready),
      .op_imem_req   (op_imem_req),
      .op_imem_addr  (op_imem_addr),
      .ip_imem_rdata (ip_imem_rdata),
      .ip_stall      (ip_stall),
      .ip_flush      (ip_flush),
      .op_if_valid   (op_if_valid),
      .op_if_pc      (op_if_pc),
      .op_if_instr   (op_if_instr),
      .op_misalign   (op_misalign)
   );

   always #5 ip_clk = ~ip_clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a == 32'h0) ? 32'h0050_0093 : (32'h1000_0000 | a);
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // One clock: memory answers the request seen before the edge, then inputs may change
   task automatic tick();
      req_d  = op_imem_req;
      addr_d = op_imem_addr;
      @(posedge ip_clk);
      #1;
      ip_imem_rdata = req_d ? instr_of(addr_d) : 32'hdead_beef;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      ip_rst = 1'b1; ip_pc = '0; ip_pc_valid = 1'b0; ip_imem_rdata = '0;
      ip_stall = 1'b0; ip_flush = 1'b0;
      #2;
      check_eq("rst_valid", op_if_valid, 0);
      check_eq("rst_pc", op_if_pc, 0);
      check_eq("rst_instr", op_if_instr, 32'h13);
      check_eq("rst_misalign", op_misalign, 0);
      check_eq("rst_ready", op_pc_ready, 0);
      tick();
      ip_rst = 1'b0;

      // basic fetch, one-cycle latency
      ip_pc = 32'h0; ip_pc_valid = 1'b1; settle();
      check_eq("t1_req", op_imem_req, 1);
      check_eq("t1_addr", op_imem_addr, 32'h0);
      tick();
      ip_pc_valid = 1'b0; settle();
      check_eq("t1_not_yet", op_if_valid, 0);
      tick(); settle();
      check_eq("t1_valid", op_if_valid, 1);
      check_eq("t1_pc", op_if_pc, 32'h0);
      check_eq("t1_instr", op_if_instr, 32'h0050_0093);
      tick(); settle();
      check_eq("t1_popped", op_if_valid, 0);

      // backpressure with stall
      ip_stall = 1'b1; ip_pc = 32'h0; ip_pc_valid = 1'b1; settle();
      check_eq("t2_ready0", op_pc_ready, 1);
      tick();
      ip_pc = 32'h4; settle();
      check_eq("t2_ready4", op_pc_ready, 1);
      tick();
      ip_pc = 32'h8; settle();
      check_eq("t2_ready8_held", op_pc_ready, 0);
      check_eq("t2_req8_held", op_imem_req, 0);
      tick(); settle();
      check_eq("t2_full_ready", op_pc_ready, 0);
      check_eq("t2_head0", op_if_pc, 32'h0);
      ip_stall = 1'b0; settle();
      check_eq("t2_still_held", op_pc_ready, 0);
      tick();
      ip_stall = 1'b1; settle();
      check_eq("t2_ready_after_pop", op_pc_ready, 1);
      check_eq("t2_head4", op_if_pc, 32'h4);
      tick();
      ip_pc_valid = 1'b0; settle();
      check_eq("t2_ready_reserved", op_pc_ready, 0);
      tick(); settle();
      check_eq("t2_head4_instr", op_if_instr, instr_of(32'h4));

      // flush with a fetch in flight
      ip_flush = 1'b1; settle();
      check_eq("t3_flush_ready", op_pc_ready, 0);
      tick();
      ip_flush = 1'b0; settle();
      check_eq("t3_cleared", op_if_valid, 0);
      ip_pc = 32'h10; ip_pc_valid = 1'b1;
      tick();
      ip_pc = 32'h14; settle();
      check_eq("t3_accept14", op_imem_req, 1);
      tick();
      ip_pc_valid = 1'b0; ip_flush = 1'b1; settle();
      check_eq("t3_head10", op_if_pc, 32'h10);
      tick();
      ip_flush = 1'b0; settle();
      check_eq("t3_flushed_valid", op_if_valid, 0);
      check_eq("t3_flushed_ready", op_pc_ready, 1);
      tick(); settle();
      check_eq("t3_dropped_word", op_if_valid, 0);

      // simultaneous pop and write across pointer wrap
      ip_pc = 32'h20; ip_pc_valid = 1'b1;
      tick();
      ip_pc = 32'h24;
      tick();
      ip_pc_valid = 1'b0; ip_stall = 1'b0; settle();
      check_eq("t4_head20", op_if_pc, 32'h20);
      tick(); settle();
      check_eq("t4_head24", op_if_pc, 32'h24);
      check_eq("t4_valid24", op_if_valid, 1);
      ip_pc = 32'h28; ip_pc_valid = 1'b1; settle();
      check_eq("t4_ready28", op_pc_ready, 1);
      tick();
      ip_pc = 32'h2c; settle();
      check_eq("t4_accept2c", op_imem_req, 1);
      tick();
      ip_pc_valid = 1'b0; settle();
      check_eq("t4_head28", op_if_pc, 32'h28);
      tick(); settle();
      check_eq("t4_head2c", op_if_pc, 32'h2c);
      check_eq("t4_instr2c", op_if_instr, instr_of(32'h2c));
      check_eq("t4_valid2c", op_if_valid, 1);
      tick(); settle();
      check_eq("t4_empty", op_if_valid, 0);

      // misaligned PC
      ip_stall = 1'b1; ip_pc = 32'h6; ip_pc_valid = 1'b1; settle();
      check_eq("t5_addr", op_imem_addr, 32'h4);
      tick();
      ip_pc_valid = 1'b0;
      tick(); settle();
      check_eq("t5_valid", op_if_valid, 1);
`ifdef FETCH_MISALIGN_CHK_EN
      check_eq("t5_misalign", op_misalign, 1);
      check_eq("t5_instr", op_if_instr, 32'h13);
`else
      check_eq("t5_misalign", op_misalign, 0);
      check_eq("t5_instr", op_if_instr, instr_of(32'h4));
`endif

      // asynchronous reset with two entries queued
      ip_pc = 32'h30; ip_pc_valid = 1'b1;
      tick();
      ip_pc_valid = 1'b0;
      tick(); settle();
      check_eq("t6_full_valid", op_if_valid, 1);
      check_eq("t6_full_ready", op_pc_ready, 0);
      #1 ip_rst = 1'b1;
      #1;
      check_eq("t6_rst_valid", op_if_valid, 0);
      check_eq("t6_rst_pc", op_if_pc, 0);
      check_eq("t6_rst_instr", op_if_instr, 32'h13);
      check_eq("t6_rst_misalign", op_misalign, 0);
      check_eq("t6_rst_ready", op_pc_ready, 0);
      tick();
      ip_rst = 1'b0; ip_stall = 1'b0;

      // reset during an in-flight fetch drops the response
      ip_pc = 32'h40; ip_pc_valid = 1'b1; settle();
      check_eq("t7_accept", op_imem_req, 1);
      tick();
      ip_pc_valid = 1'b0;
      #1 ip_rst = 1'b1;
      #1 ip_rst = 1'b0;
      tick(); settle();
      check_eq("t7_dropped", op_if_valid, 0);
      check_eq("t7_ready", op_pc_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
